daq_scan_sequencer: RTL and testbench
=====================================

DAQ_SCAN_SEQUENCER -- requirements
Module: daq_scan_sequencer

Interface
REQ-001 Parameters SHALL be: aw, 32, address width; dw, 32, data width; FIFO_DEPTH, 16, result FIFO entries (power of 2).
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-003 wb_clk  in  1  sole clock, all state on rising edge.
REQ-004 wb_rst  in  1  asynchronous, active-low reset.
REQ-005 enable  in  1  level; 1 = periodic scanning allowed.
REQ-006 period  in  16  sample period in wb_clk cycles (0 treated as 1).
REQ-007 base_address  in  aw  address of channel 0.
REQ-008 num_ch  in  3  channels per scan minus 1 (0..7 = 1..8 channels).
REQ-009 start  out  1  one-cycle transaction request to the DAQ master.
REQ-010 address  out  aw  transaction address, held from start until done.
REQ-011 selection  out  4  byte select; 4'hF during a transaction, else 0.
REQ-012 write  out  1  constant 0 (read-only sequencer).
REQ-013 data_wr  out  dw  constant 0.
REQ-014 data_rd  in  dw  read data from the master, valid on active falling edge.
REQ-015 active  in  1  master busy flag.
REQ-016 fifo_pop  in  1  consume head entry.
REQ-017 fifo_data  out  dw  head data, first-word-fall-through.
REQ-018 fifo_ch  out  3  channel index of head entry.
REQ-019 fifo_empty, fifo_full  out  1 each  FIFO status.
REQ-020 fifo_count  out  clog2(FIFO_DEPTH)+1  occupancy.
REQ-021 status  out  3  sticky {timeout, scan_overrun, fifo_overflow}; status_clr  in  1  clears all three.

Function
REQ-022 The tick timer SHALL count 0..max(period,1)-1 while enable=1, pulsing tick for one cycle at the terminal count and reloading 0; enable=0 SHALL hold the timer at 0.
REQ-023 The FSM SHALL have states IDLE, ISSUE, WAIT_ACT, WAIT_DONE, STORE, NEXT.
REQ-024 IDLE->ISSUE on tick; ch counter SHALL load 0.
REQ-025 ISSUE SHALL assert start for exactly one cycle with address = base_address + 4*ch (mod 2^aw), then go to WAIT_ACT.
REQ-026 WAIT_ACT->WAIT_DONE when active=1; WAIT_DONE->STORE when active=0.
REQ-027 STORE SHALL capture data_rd in the same cycle active is first seen low and push {ch, data_rd} into the FIFO.
REQ-028 NEXT SHALL go to ISSUE with ch+1 if ch<num_ch and enable=1, else to IDLE.
REQ-029 A tick outside IDLE SHALL be dropped and set scan_overrun.
REQ-030 A 256-cycle watchdog SHALL run in WAIT_ACT and WAIT_DONE; expiry sets timeout, aborts the scan, and returns to IDLE without a push.
REQ-031 enable deasserted mid-scan SHALL let the current transaction complete and store, then return to IDLE.
REQ-032 num_ch and base_address SHALL be sampled at scan start (IDLE->ISSUE) and held for the scan.
REQ-033 A push when full without a same-cycle pop SHALL be discarded and set fifo_overflow; a push and pop together when full SHALL both succeed with count unchanged.
REQ-034 A pop when empty SHALL be ignored, with count held at 0.
REQ-035 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-036 status_clr SHALL take priority over a same-cycle set.

Reset
REQ-037 On wb_rst=0 the block SHALL zero start, address, selection, timer, and ch; set the FSM to IDLE; empty the FIFO (fifo_empty=1, fifo_count=0, fifo_full=0); and clear status.
REQ-038 Reset mid-transaction SHALL abandon the transaction with no push.

Structure
REQ-039 State encodings, the watchdog limit (256), and the status bit indices SHALL live in shared package daq_pkg.
REQ-040 The FIFO SHALL be a separate sub-module, daq_sync_fifo, parameterised by width and depth.

Verification
REQ-041 period=10, num_ch=1, base=0x1000, and a master model with active for 3 cycles SHALL produce start pulses at 0x1000 and 0x1004, then FIFO entries (0,D0) and (1,D1), with the next scan 10 cycles after the first tick.
REQ-042 With FIFO_DEPTH=16, no pops, and 17 reads, fifo_full SHALL be 1, count 16, and status[0] set, with the 17th value absent.
REQ-043 period=2 with a 3-channel scan SHALL set status[1] while the scan still completes all 3 entries.
REQ-044 With active never asserted, status[2] SHALL set 256 cycles after start, the FSM SHALL return to IDLE, and the FIFO SHALL stay empty.
REQ-045 Reset asserted during WAIT_DONE SHALL give start=0, address=0, fifo_empty=1, and no push after release.
REQ-046 Pop with push on a full FIFO SHALL keep count at 16, and the head SHALL advance by one entry.

Source files
------------

// File: rtl/daq_pkg.sv
// Shared definitions for the DAQ scan sequencer: FSM encoding, watchdog
// limit and status bit positions.
package daq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ACT  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_STORE     = 3'd4,
        ST_NEXT      = 3'd5
    } seq_state_t;

    localparam int WDOG_LIMIT = 256;
    localparam int WDOG_W     = $clog2(WDOG_LIMIT);

    localparam int STAT_W        = 3;
    localparam int STAT_OVERFLOW = 0;
    localparam int STAT_OVERRUN  = 1;
    localparam int STAT_TIMEOUT  = 2;

    // A programmed period of zero behaves as a one-cycle period.
    function automatic logic [15:0] eff_period(input logic [15:0] p);
        return (p == 16'd0) ? 16'd1 : p;
    endfunction

endpackage

// File: rtl/daq_sync_fifo.sv
// Single-clock first-word-fall-through FIFO holding scan results.
// Supports simultaneous push and pop while full.
module daq_sync_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty    = (r_count == '0);
    assign full     = (r_count == (PW+1)'(DEPTH));
    assign count    = r_count;
    assign rdata    = r_mem[r_rd_ptr];

    // When full, a same-cycle pop frees the slot the push lands in.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || pop);
    assign overflow  = push && full && !pop;

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_do_push && !w_do_pop)
                r_count <= r_count + (PW+1)'(1);
            else if (w_do_pop && !w_do_push)
                r_count <= r_count - (PW+1)'(1);
        end
    end

endmodule

// File: rtl/daq_scan_sequencer.sv
// Periodic multi-channel read sequencer: issues one read per channel to a
// DAQ master on every scan tick and queues {channel, data} results.
module daq_scan_sequencer #(
    parameter int aw         = 32,
    parameter int dw         = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          wb_clk,
    input  logic                          wb_rst,
    input  logic                          enable,
    input  logic [15:0]                   period,
    input  logic [aw-1:0]                 base_address,
    input  logic [2:0]                    num_ch,
    output logic                          start,
    output logic [aw-1:0]                 address,
    output logic [3:0]                    selection,
    output logic                          write,
    output logic [dw-1:0]                 data_wr,
    input  logic [dw-1:0]                 data_rd,
    input  logic                          active,
    input  logic                          fifo_pop,
    output logic [dw-1:0]                 fifo_data,
    output logic [2:0]                    fifo_ch,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [2:0]                    status,
    input  logic                          status_clr
);

    import daq_pkg::*;

    seq_state_t        r_state;
    logic [15:0]       r_timer;
    logic [2:0]        r_ch;
    logic [2:0]        r_nch;
    logic [aw-1:0]     r_base;
    logic [WDOG_W-1:0] r_wdog;
    logic              r_start;
    logic [aw-1:0]     r_address;
    logic [3:0]        r_sel;
    logic              r_push;
    logic [dw+2:0]     r_push_data;
    logic [STAT_W-1:0] r_status;

    logic [15:0]       w_period;
    logic              w_tick;
    logic              w_wd_exp;
    logic              w_timeout;
    logic              w_overrun;
    logic              w_overflow;
    logic [2:0]        w_ch_next;
    logic [aw-1:0]     w_next_addr;
    logic [STAT_W-1:0] w_set;
    logic [dw+2:0]     w_fifo_rdata;

    assign w_period    = eff_period(period);
    assign w_tick      = enable && (r_timer >= (w_period - 16'd1));
    assign w_wd_exp    = (r_wdog == WDOG_W'(WDOG_LIMIT - 1));
    assign w_timeout   = w_wd_exp && (((r_state == ST_WAIT_ACT) && !active) ||
                                      ((r_state == ST_WAIT_DONE) && active));
    assign w_overrun   = w_tick && (r_state != ST_IDLE);
    assign w_ch_next   = r_ch + 3'd1;
    assign w_next_addr = r_base + (aw'(w_ch_next) << 2);

    assign start     = r_start;
    assign address   = r_address;
    assign selection = r_sel;
    assign write     = 1'b0;
    assign data_wr   = '0;
    assign status    = r_status;
    assign fifo_ch   = w_fifo_rdata[dw+2:dw];
    assign fifo_data = w_fifo_rdata[dw-1:0];

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst)
            r_timer <= 16'd0;
        else if (!enable || w_tick)
            r_timer <= 16'd0;
        else
            r_timer <= r_timer + 16'd1;
    end

    // One watchdog budget covers both the wait-for-busy and wait-for-done phases.
    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            r_state   <= ST_IDLE;
            r_ch      <= 3'd0;
            r_wdog    <= '0;
            r_start   <= 1'b0;
            r_address <= '0;
            r_sel     <= 4'h0;
            r_push    <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_push  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_state   <= ST_ISSUE;
                        r_ch      <= 3'd0;
                        r_start   <= 1'b1;
                        r_address <= base_address;
                        r_sel     <= 4'hF;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT_ACT;
                    r_wdog  <= '0;
                end
                ST_WAIT_ACT: begin
                    if (w_timeout) begin
                        r_state <= ST_IDLE;
                        r_sel   <= 4'h0;
                    end else begin
                        r_wdog <= r_wdog + WDOG_W'(1);
                        if (active)
                            r_state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (w_timeout) begin
                        r_state <= ST_IDLE;
                        r_sel   <= 4'h0;
                    end else begin
                        r_wdog <= r_wdog + WDOG_W'(1);
                        if (!active) begin
                            r_state <= ST_STORE;
                            r_push  <= 1'b1;
                            r_sel   <= 4'h0;
                        end
                    end
                end
                ST_STORE: begin
                    r_state <= ST_NEXT;
                end
                ST_NEXT: begin
                    if ((r_ch < r_nch) && enable) begin
                        r_state   <= ST_ISSUE;
                        r_ch      <= w_ch_next;
                        r_start   <= 1'b1;
                        r_address <= w_next_addr;
                        r_sel     <= 4'hF;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Scan configuration is frozen at scan start; read data is taken as done is seen.
    always_ff @(posedge wb_clk) begin
        if ((r_state == ST_IDLE) && w_tick) begin
            r_base <= base_address;
            r_nch  <= num_ch;
        end
        if ((r_state == ST_WAIT_DONE) && !active)
            r_push_data <= {r_ch, data_rd};
    end

    always_comb begin
        w_set                = '0;
        w_set[STAT_TIMEOUT]  = w_timeout;
        w_set[STAT_OVERRUN]  = w_overrun;
        w_set[STAT_OVERFLOW] = w_overflow;
    end

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst)
            r_status <= '0;
        else if (status_clr)
            r_status <= '0;
        else
            r_status <= r_status | w_set;
    end

    daq_sync_fifo #(
        .WIDTH (dw + 3),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (wb_clk),
        .rst_n    (wb_rst),
        .push     (r_push),
        .pop      (fifo_pop),
        .wdata    (r_push_data),
        .rdata    (w_fifo_rdata),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (fifo_count),
        .overflow (w_overflow)
    );

endmodule

// File: tb/tb_daq_scan_sequencer.sv
// Directed bench for daq_scan_sequencer with a simple DAQ master model that
// holds active for three cycles per transaction.
`timescale 1ns/1ps
module tb_daq_scan_sequencer;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          wb_clk = 1'b0;
    logic          wb_rst = 1'b1;
    logic          enable;
    logic [15:0]   period;
    logic [AW-1:0] base_address;
    logic [2:0]    num_ch;
    logic          start;
    logic [AW-1:0] address;
    logic [3:0]    selection;
    logic          write;
    logic [DW-1:0] data_wr;
    logic [DW-1:0] data_rd;
    logic          active;
    logic          fifo_pop;
    logic [DW-1:0] fifo_data;
    logic [2:0]    fifo_ch;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic [2:0]    status;
    logic          status_clr;

    daq_scan_sequencer #(.aw(AW), .dw(DW), .FIFO_DEPTH(DEPTH)) dut (
        .wb_clk       (wb_clk),
        .wb_rst       (wb_rst),
        .enable       (enable),
        .period       (period),
        .base_address (base_address),
        .num_ch       (num_ch),
        .start        (start),
        .address      (address),
        .selection    (selection),
        .write        (write),
        .data_wr      (data_wr),
        .data_rd      (data_rd),
        .active       (active),
        .fifo_pop     (fifo_pop),
        .fifo_data    (fifo_data),
        .fifo_ch      (fifo_ch),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .fifo_count   (fifo_count),
        .status       (status),
        .status_clr   (status_clr)
    );

    always #5 wb_clk = ~wb_clk;

    int cyc = 0;
    always @(posedge wb_clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] st_addr [$];
    int            st_cyc  [$];
    bit            m_silent = 1'b0;
    int            m_next   = 0;

    function automatic logic [31:0] dval(input int n);
        return 32'hD000_0000 + 32'(n);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge wb_clk);
        #2;
    endtask

    task automatic wait_starts(input int n, input int budget, input string tag);
        int k = 0;
        while (st_addr.size() < n && k < budget) begin
            step(1);
            k++;
        end
        check(tag, 64'(st_addr.size() >= n), 64'd1);
    endtask

    task automatic wait_active_fall(input int budget, input string tag);
        int   k    = 0;
        bit   seen = 1'b0;
        logic prev = active;
        while (!seen && k < budget) begin
            step(1);
            k++;
            if (prev && !active) seen = 1'b1;
            prev = active;
        end
        check(tag, 64'(seen), 64'd1);
    endtask

    task automatic pop1();
        fifo_pop = 1'b1;
        step(1);
        fifo_pop = 1'b0;
    endtask

    // Master model: active high for three cycles, read data valid as it falls,
    // then replaced by junk so a late capture would be visible.
    initial begin
        active  = 1'b0;
        data_rd = '0;
        forever begin
            @(posedge wb_clk);
            #1;
            if (start === 1'b1) begin
                st_addr.push_back(address);
                st_cyc.push_back(cyc);
                if (!m_silent) begin
                    active = 1'b1;
                    repeat (3) @(posedge wb_clk);
                    #1;
                    active  = 1'b0;
                    data_rd = dval(m_next);
                    m_next++;
                    @(posedge wb_clk);
                    #1;
                    data_rd = 32'hBAD0_0000;
                end
            end
        end
    end

    initial begin
        #200000;
        $error("FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        int            k0;
        int            s0;
        logic [DW+2:0] exp_e;

        wb_rst       = 1'b0;
        enable       = 1'b0;
        period       = 16'd10;
        base_address = '0;
        num_ch       = 3'd0;
        fifo_pop     = 1'b0;
        status_clr   = 1'b0;
        step(3);
        check("rst_start",     64'(start),      64'd0);
        check("rst_address",   64'(address),    64'd0);
        check("rst_selection", 64'(selection),  64'd0);
        check("rst_empty",     64'(fifo_empty), 64'd1);
        check("rst_full",      64'(fifo_full),  64'd0);
        check("rst_count",     64'(fifo_count), 64'd0);
        check("rst_status",    64'(status),     64'd0);
        wb_rst = 1'b1;
        step(2);
        check("const_write",   64'(write),      64'd0);
        check("const_data_wr", 64'(data_wr),    64'd0);

        // Two-channel scan at 0x1000, enable dropped during the second read.
        period = 16'd10; num_ch = 3'd1; base_address = 32'h1000;
        st_addr.delete(); st_cyc.delete();
        k0 = cyc;
        enable = 1'b1;
        wait_starts(1, 40, "A_start0_wait");
        check("A_sel_busy", 64'(selection), 64'hF);
        wait_starts(2, 40, "A_start1_wait");
        enable = 1'b0;
        step(12);
        check("A_addr0",    64'(st_addr[0]), 64'h1000);
        check("A_addr1",    64'(st_addr[1]), 64'h1004);
        check("A_latency",  64'(st_cyc[0] - k0), 64'd10);
        check("A_count",    64'(fifo_count), 64'd2);
        check("A_sel_idle", 64'(selection), 64'd0);
        check("A_head0",    64'({fifo_ch, fifo_data}), 64'({3'd0, dval(0)}));
        pop1();
        check("A_head1",    64'({fifo_ch, fifo_data}), 64'({3'd1, dval(1)}));
        pop1();
        check("A_empty",    64'(fifo_empty), 64'd1);
        step(20);
        check("A_no_rescan", 64'(st_addr.size()), 64'd2);
        check("A_status",    64'(status), 64'd0);

        // Single-channel scans recur exactly one period apart.
        num_ch = 3'd0;
        st_addr.delete(); st_cyc.delete();
        k0 = cyc;
        enable = 1'b1;
        wait_starts(2, 60, "B_start_wait");
        enable = 1'b0;
        check("B_latency",  64'(st_cyc[0] - k0), 64'd10);
        check("B_interval", 64'(st_cyc[1] - st_cyc[0]), 64'd10);
        step(12);
        check("B_count", 64'(fifo_count), 64'd2);
        check("B_head0", 64'({fifo_ch, fifo_data}), 64'({3'd0, dval(2)}));
        pop1();
        check("B_head1", 64'({fifo_ch, fifo_data}), 64'({3'd0, dval(3)}));
        pop1();
        check("B_status", 64'(status), 64'd0);

        // Seventeen reads into a 16-entry FIFO with no pops.
        period = 16'd60; num_ch = 3'd7; base_address = 32'h2000;
        st_addr.delete(); st_cyc.delete();
        enable = 1'b1;
        wait_starts(17, 300, "C_start_wait");
        enable = 1'b0;
        step(12);
        check("C_full",   64'(fifo_full),  64'd1);
        check("C_count",  64'(fifo_count), 64'd16);
        check("C_status", 64'(status),     64'b001);
        check("C_head",   64'({fifo_ch, fifo_data}), 64'({3'd0, dval(4)}));
        status_clr = 1'b1;
        step(1);
        status_clr = 1'b0;
        check("C_clr", 64'(status), 64'd0);

        // Pop in the same cycle as the store while full.
        num_ch = 3'd0;
        st_addr.delete(); st_cyc.delete();
        enable = 1'b1;
        wait_starts(1, 80, "P_start_wait");
        enable = 1'b0;
        wait_active_fall(10, "P_fall_wait");
        step(1);
        fifo_pop = 1'b1;
        step(1);
        fifo_pop = 1'b0;
        check("P_count",  64'(fifo_count), 64'd16);
        check("P_full",   64'(fifo_full),  64'd1);
        check("P_status", 64'(status),     64'd0);
        check("P_head",   64'({fifo_ch, fifo_data}), 64'({3'd1, dval(5)}));
        for (int i = 0; i < 16; i++) begin
            exp_e = (i < 15) ? {3'((i + 1) % 8), dval(5 + i)} : {3'd0, dval(21)};
            check($sformatf("P_drain%0d", i), 64'({fifo_ch, fifo_data}), 64'(exp_e));
            pop1();
        end
        check("P_empty", 64'(fifo_empty), 64'd1);
        pop1();
        check("P_pop_empty_count", 64'(fifo_count), 64'd0);
        check("P_pop_empty_flag",  64'(fifo_empty), 64'd1);

        // Period of 2 overruns a three-channel scan, which still completes.
        period = 16'd2; num_ch = 3'd2; base_address = 32'h3000;
        st_addr.delete(); st_cyc.delete();
        enable = 1'b1;
        wait_starts(3, 60, "D_start_wait");
        enable = 1'b0;
        step(12);
        check("D_status", 64'(status), 64'b010);
        check("D_count",  64'(fifo_count), 64'd3);
        check("D_addr0",  64'(st_addr[0]), 64'h3000);
        check("D_addr1",  64'(st_addr[1]), 64'h3004);
        check("D_addr2",  64'(st_addr[2]), 64'h3008);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("D_entry%0d", i), 64'({fifo_ch, fifo_data}),
                  64'({3'(i), dval(22 + i)}));
            pop1();
        end
        status_clr = 1'b1;
        step(1);
        status_clr = 1'b0;

        // Master never responds: watchdog aborts the scan.
        m_silent = 1'b1;
        period = 16'd10; num_ch = 3'd0; base_address = 32'h5000;
        st_addr.delete(); st_cyc.delete();
        enable = 1'b1;
        wait_starts(1, 40, "E_start_wait");
        enable = 1'b0;
        s0 = st_cyc[0];
        step(100);
        check("E_sel_waiting", 64'(selection), 64'hF);
        step(s0 + 255 - cyc);
        check("E_not_yet", 64'(status), 64'd0);
        step(3);
        check("E_timeout",  64'(status),     64'b100);
        check("E_sel_idle", 64'(selection),  64'd0);
        check("E_empty",    64'(fifo_empty), 64'd1);
        check("E_count",    64'(fifo_count), 64'd0);
        m_silent = 1'b0;
        status_clr = 1'b1;
        step(1);
        status_clr = 1'b0;
        enable = 1'b1;
        wait_starts(2, 40, "E_rescan_wait");
        enable = 1'b0;
        step(12);
        check("E_rescan_entry", 64'({fifo_ch, fifo_data}), 64'({3'd0, dval(25)}));
        pop1();

        // Reset while waiting for done abandons the read.
        base_address = 32'h4000;
        st_addr.delete(); st_cyc.delete();
        enable = 1'b1;
        wait_starts(1, 40, "F_start_wait");
        enable = 1'b0;
        step(2);
        check("F_addr_before", 64'(address), 64'h4000);
        wb_rst = 1'b0;
        #1;
        check("F_rst_start",   64'(start),      64'd0);
        check("F_rst_address", 64'(address),    64'd0);
        check("F_rst_sel",     64'(selection),  64'd0);
        check("F_rst_empty",   64'(fifo_empty), 64'd1);
        step(2);
        wb_rst = 1'b1;
        step(10);
        check("F_no_push_empty", 64'(fifo_empty), 64'd1);
        check("F_no_push_count", 64'(fifo_count), 64'd0);
        check("F_status",        64'(status),     64'd0);
        check("F_no_restart",    64'(st_addr.size()), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
